flexbex_ibex_mc_issue_ctrl: RTL and testbench

Parametrised multicycle issue/stall controller for the flexbex ID stage. It generalises the fixed load/multdiv/eFPGA/branch/jump stall FSM to N_UNITS functional-unit channels. Each channel is either handshake-completed (waits for ready) or fixed-latency (runs a countdown). The block issues one operation at a time, stalls ID, captures the owning unit, and gates register-file writeback and its source select.

---
 rtl/flexbex_ibex_mc_pkg.sv | 24 ++
 rtl/flexbex_ibex_mc_prio_enc.sv | 32 +++
 rtl/flexbex_ibex_mc_issue_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_flexbex_ibex_mc_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_ibex_mc_pkg.sv
// flexbex_ibex_mc_pkg
//   Shared definitions for the multicycle issue/stall controller:
//   - mc_state_e  : controller state encoding (IDLE, MULTI, BRANCH, JUMP)
//   - UNIT_*      : default channel indices for the stock unit mapping
//   - wb_sel_alu  : writeback-select code for the ALU/CSR path, which is
//                   the first code past the last unit index
package flexbex_ibex_mc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULTI  = 2'd1,
    BRANCH = 2'd2,
    JUMP   = 2'd3
  } mc_state_e;

  localparam int unsigned UNIT_LSU    = 0;
  localparam int unsigned UNIT_MULDIV = 1;
  localparam int unsigned UNIT_EFPGA  = 2;

  function automatic int unsigned wb_sel_alu(input int unsigned n_units);
    return n_units;
  endfunction

endpackage

// File: rtl/flexbex_ibex_mc_prio_enc.sv
// flexbex_ibex_mc_prio_enc
//   Lowest-index-first priority encoder.
//   Parameters: N (request width), IDX_W (index width)
//   Ports:
//     req    in  N      request vector
//     onehot out N      the single winning request bit (or zero)
//     idx    out IDX_W  index of the winning request (0 when none)
//     valid  out 1      at least one request set
module flexbex_ibex_mc_prio_enc #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flexbex_ibex_mc_issue_ctrl.sv
// flexbex_ibex_mc_issue_ctrl
//   Multicycle issue/stall controller for the flexbex ID stage. Issues one
//   operation at a time to one of N_UNITS channels (handshake or fixed
//   latency), stalls ID while it runs, and gates regfile writeback and its
//   source select. Also handles taken-branch and jump stall cycles.
//   Optional watchdog on handshake units: define FLEXBEX_MC_TIMEOUT_EN.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     instr_valid_i       decoded instruction valid
//     unit_req_i          per-unit issue request from decoder
//     branch_in_id_i      conditional branch in ID
//     branch_decision_i   branch taken
//     jump_in_id_i        jump in ID
//     regfile_we_id_i     decoder writeback enable
//     unit_ready_i        per-unit completion (handshake units only)
//     unit_delay_i        latency for a fixed-latency unit issued this cycle
//     kill_i              flush; beats issue and completion
//     unit_en_o           one-cycle one-hot issue pulse
//     id_ready_o          ID may accept next instruction
//     instr_multicycle_o  multicycle operation in progress
//     regfile_we_o        gated writeback enable
//     wb_sel_o            writeback source (unit index, N_UNITS = ALU/CSR)
//     branch_set_o        registered taken-branch flag
//     jump_set_o          jump issue pulse
//     perf_branch_o       branch-seen pulse
//     busy_o              controller not idle
//     timeout_err_o       watchdog pulse (0 without FLEXBEX_MC_TIMEOUT_EN)
module flexbex_ibex_mc_issue_ctrl
  import flexbex_ibex_mc_pkg::*;
#(
  parameter int unsigned          N_UNITS        = 3,
  parameter logic [N_UNITS-1:0]   FIXED_LAT_MASK = 3'b100,
  parameter int unsigned          DELAY_W        = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_valid_i,
  input  logic [N_UNITS-1:0]            unit_req_i,
  input  logic                          branch_in_id_i,
  input  logic                          branch_decision_i,
  input  logic                          jump_in_id_i,
  input  logic                          regfile_we_id_i,
  input  logic [N_UNITS-1:0]            unit_ready_i,
  input  logic [DELAY_W-1:0]            unit_delay_i,
  input  logic                          kill_i,
  output logic [N_UNITS-1:0]            unit_en_o,
  output logic                          id_ready_o,
  output logic                          instr_multicycle_o,
  output logic                          regfile_we_o,
  output logic [$clog2(N_UNITS+1)-1:0]  wb_sel_o,
  output logic                          branch_set_o,
  output logic                          jump_set_o,
  output logic                          perf_branch_o,
  output logic                          busy_o,
  output logic                          timeout_err_o
);

  localparam int unsigned        WB_SEL_W = $clog2(N_UNITS + 1);
  localparam logic [WB_SEL_W-1:0] WB_ALU  = WB_SEL_W'(wb_sel_alu(N_UNITS));

  mc_state_e             state_q, state_d;
  logic [DELAY_W-1:0]    cnt_q, cnt_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  branch_set_q, branch_set_d;

  logic [N_UNITS-1:0]    req_onehot;
  logic [WB_SEL_W-1:0]   req_idx;
  logic                  req_valid;

  logic                  cur_fixed;
  logic                  cur_ready;
  logic                  done;
  logic                  timeout;

  // Combinational outputs before reset gating
  logic [N_UNITS-1:0]    unit_en;
  logic                  id_ready, multicycle, regfile_we, jump_set, perf_branch;
  logic [WB_SEL_W-1:0]   wb_sel;

  flexbex_ibex_mc_prio_enc #(
    .N     (N_UNITS),
    .IDX_W (WB_SEL_W)
  ) u_prio_enc (
    .req    (unit_req_i),
    .onehot (req_onehot),
    .idx    (req_idx),
    .valid  (req_valid)
  );

  // Attributes of the unit currently owning the controller
  always_comb begin
    cur_fixed = 1'b0;
    cur_ready = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (sel_q == WB_SEL_W'(i)) begin
        cur_fixed = FIXED_LAT_MASK[i];
        cur_ready = unit_ready_i[i];
      end
    end
  end

  assign done = cur_fixed ? (cnt_q == '0) : cur_ready;

`ifdef FLEXBEX_MC_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog runs only while a handshake unit is outstanding
  always_comb begin
    wd_d    = wd_q;
    timeout = 1'b0;
    if (state_q != MULTI) begin
      wd_d = '0;
    end else if (!cur_fixed && !done && !kill_i) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    branch_set_d = branch_set_q;
    unit_en      = '0;
    id_ready     = 1'b0;
    multicycle   = 1'b0;
    regfile_we   = 1'b0;
    wb_sel       = WB_ALU;
    jump_set     = 1'b0;
    perf_branch  = 1'b0;

    unique case (state_q)
      IDLE: begin
        id_ready = 1'b1;
        if (instr_valid_i && !kill_i) begin
          if (req_valid) begin
            unit_en    = req_onehot;
            id_ready   = 1'b0;
            multicycle = 1'b1;
            sel_d      = req_idx;
            if (|(req_onehot & FIXED_LAT_MASK)) cnt_d = unit_delay_i;
            state_d    = MULTI;
          end else if (branch_in_id_i) begin
            perf_branch = 1'b1;
            if (branch_decision_i) begin
              branch_set_d = 1'b1;
              id_ready     = 1'b0;
              multicycle   = 1'b1;
              state_d      = BRANCH;
            end
          end else if (jump_in_id_i) begin
            jump_set = 1'b1;
            id_ready = 1'b0;
            state_d  = JUMP;
          end else begin
            regfile_we = regfile_we_id_i;
          end
        end
      end

      MULTI: begin
        if (kill_i || timeout) begin
          state_d = IDLE;
        end else if (done) begin
          regfile_we = regfile_we_id_i;
          wb_sel     = sel_q;
          id_ready   = 1'b1;
          state_d    = IDLE;
        end else begin
          multicycle = 1'b1;
          if (cur_fixed) cnt_d = cnt_q - DELAY_W'(1);
        end
      end

      BRANCH: begin
        branch_set_d = 1'b0;
        id_ready     = !kill_i;
        state_d      = IDLE;
      end

      JUMP: begin
        id_ready   = !kill_i;
        regfile_we = regfile_we_id_i && !kill_i;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      branch_set_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      branch_set_q <= branch_set_d;
    end
  end

  // While reset is asserted, present the idle/ready values on every output
  assign unit_en_o          = rst_n ? unit_en : '0;
  assign id_ready_o         = rst_n ? id_ready : 1'b1;
  assign instr_multicycle_o = rst_n & multicycle;
  assign regfile_we_o       = rst_n & regfile_we;
  assign wb_sel_o           = rst_n ? wb_sel : WB_ALU;
  assign branch_set_o       = rst_n & branch_set_q;
  assign jump_set_o         = rst_n & jump_set;
  assign perf_branch_o      = rst_n & perf_branch;
  assign busy_o             = rst_n & (state_q != IDLE);
  assign timeout_err_o      = rst_n & timeout & (TIMEOUT_CYCLES > 1);

endmodule

// File: tb/tb_flexbex_ibex_mc_issue_ctrl.sv
module tb_flexbex_ibex_mc_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid_i;
  logic [2:0] unit_req_i;
  logic       branch_in_id_i;
  logic       branch_decision_i;
  logic       jump_in_id_i;
  logic       regfile_we_id_i;
  logic [2:0] unit_ready_i;
  logic [3:0] unit_delay_i;
  logic       kill_i;
  logic [2:0] unit_en_o;
  logic       id_ready_o;
  logic       instr_multicycle_o;
  logic       regfile_we_o;
  logic [1:0] wb_sel_o;
  logic       branch_set_o;
  logic       jump_set_o;
  logic       perf_branch_o;
  logic       busy_o;
  logic       timeout_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flexbex_ibex_mc_issue_ctrl #(
    .N_UNITS        (3),
    .FIXED_LAT_MASK (3'b100),
    .DELAY_W        (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instr_valid_i      (instr_valid_i),
    .unit_req_i         (unit_req_i),
    .branch_in_id_i     (branch_in_id_i),
    .branch_decision_i  (branch_decision_i),
    .jump_in_id_i       (jump_in_id_i),
    .regfile_we_id_i    (regfile_we_id_i),
    .unit_ready_i       (unit_ready_i),
    .unit_delay_i       (unit_delay_i),
    .kill_i             (kill_i),
    .unit_en_o          (unit_en_o),
    .id_ready_o         (id_ready_o),
    .instr_multicycle_o (instr_multicycle_o),
    .regfile_we_o       (regfile_we_o),
    .wb_sel_o           (wb_sel_o),
    .branch_set_o       (branch_set_o),
    .jump_set_o         (jump_set_o),
    .perf_branch_o      (perf_branch_o),
    .busy_o             (busy_o),
    .timeout_err_o      (timeout_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs shortly after the edge, settle before checks
  task automatic cyc(input logic v, input logic [2:0] req, input logic br, input logic dec,
                     input logic jmp, input logic we_id, input logic [2:0] rdy,
                     input logic [3:0] dly, input logic kill);
    @(posedge clk);
    #1;
    instr_valid_i     = v;
    unit_req_i        = req;
    branch_in_id_i    = br;
    branch_decision_i = dec;
    jump_in_id_i      = jmp;
    regfile_we_id_i   = we_id;
    unit_ready_i      = rdy;
    unit_delay_i      = dly;
    kill_i            = kill;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid_i = 0; unit_req_i = '0; branch_in_id_i = 0; branch_decision_i = 0;
    jump_in_id_i = 0; regfile_we_id_i = 0; unit_ready_i = '0; unit_delay_i = '0; kill_i = 0;

    // Reset values
    cyc(1, 3'b001, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("rst_id_ready", id_ready_o, 1);
    chk("rst_wb_sel", wb_sel_o, 3);
    chk("rst_unit_en", unit_en_o, 0);
    chk("rst_we", regfile_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_err_o, 0);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    rst_n = 1'b1;

    // Single-cycle ALU op
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("alu_we", regfile_we_o, 1);
    chk("alu_wb_sel", wb_sel_o, 3);
    chk("alu_id_ready", id_ready_o, 1);

    // Fixed-latency eFPGA, delay 3: completes 4 cycles after issue
    cyc(1, 3'b100, 0, 0, 0, 1, 3'b000, 4'd3, 0);
    chk("efpga_en", unit_en_o, 3'b100);
    chk("efpga_issue_rdy", id_ready_o, 0);
    chk("efpga_issue_mc", instr_multicycle_o, 1);
    chk("efpga_issue_we", regfile_we_o, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 3'b000, 0, 0, 0, 1, 3'b111, 4'd0, 0);
      chk("efpga_wait_rdy", id_ready_o, 0);
      chk("efpga_wait_we", regfile_we_o, 0);
      chk("efpga_wait_en", unit_en_o, 0);
      chk("efpga_wait_busy", busy_o, 1);
    end
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("efpga_done_we", regfile_we_o, 1);
    chk("efpga_done_sel", wb_sel_o, 2);
    chk("efpga_done_rdy", id_ready_o, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("efpga_idle_busy", busy_o, 0);

    // LSU handshake; ready in issue cycle ignored, then ready 5 cycles after issue
    cyc(1, 3'b001, 0, 0, 0, 1, 3'b001, 4'd0, 0);
    chk("lsu_en", unit_en_o, 3'b001);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
      chk("lsu_wait_rdy", id_ready_o, 0);
      chk("lsu_wait_we", regfile_we_o, 0);
      chk("lsu_wait_sel", wb_sel_o, 3);
    end
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b001, 4'd0, 0);
    chk("lsu_done_we", regfile_we_o, 1);
    chk("lsu_done_sel", wb_sel_o, 0);
    chk("lsu_done_rdy", id_ready_o, 1);
    cyc(0, 3'b000, 0, 0, 0, 1, 3'b001, 4'd0, 0);
    chk("lsu_single_wb", regfile_we_o, 0);
    chk("lsu_idle_busy", busy_o, 0);

    // Taken branch: one stall, registered flag next cycle
    cyc(1, 3'b000, 1, 1, 0, 0, 3'b000, 4'd0, 0);
    chk("br_perf", perf_branch_o, 1);
    chk("br_stall", id_ready_o, 0);
    chk("br_set_now", branch_set_o, 0);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("br_set_next", branch_set_o, 1);
    chk("br_ready_next", id_ready_o, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("br_set_clear", branch_set_o, 0);
    chk("br_idle_busy", busy_o, 0);

    // Not-taken branch: no stall
    cyc(1, 3'b000, 1, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("nbr_perf", perf_branch_o, 1);
    chk("nbr_ready", id_ready_o, 1);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("nbr_busy", busy_o, 0);
    chk("nbr_set", branch_set_o, 0);

    // Jump with link write
    cyc(1, 3'b000, 0, 0, 1, 1, 3'b000, 4'd0, 0);
    chk("jmp_set", jump_set_o, 1);
    chk("jmp_we0", regfile_we_o, 0);
    chk("jmp_stall", id_ready_o, 0);
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("jmp_link_we", regfile_we_o, 1);
    chk("jmp_link_sel", wb_sel_o, 3);
    chk("jmp_ready", id_ready_o, 1);

    // Kill beats completion on MULDIV
    cyc(1, 3'b010, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("kill_issue_en", unit_en_o, 3'b010);
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b010, 4'd0, 1);
    chk("kill_we", regfile_we_o, 0);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("kill_busy", busy_o, 0);
    chk("kill_ready", id_ready_o, 1);

    // Kill beats issue in IDLE
    cyc(1, 3'b001, 0, 0, 0, 1, 3'b000, 4'd0, 1);
    chk("kill_idle_en", unit_en_o, 0);
    chk("kill_idle_we", regfile_we_o, 0);
    cyc(0, 3'b000, 0, 0, 0, 0, 3'b000, 4'd0, 0);
    chk("kill_idle_busy", busy_o, 0);

    // Conflicting requests: lowest index wins
    cyc(1, 3'b110, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("conf_en", unit_en_o, 3'b010);
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b110, 4'd0, 0);
    chk("conf_done_sel", wb_sel_o, 1);
    chk("conf_done_we", regfile_we_o, 1);

    // Fixed-latency delay 0 completes in the cycle after issue
    cyc(1, 3'b100, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("d0_en", unit_en_o, 3'b100);
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("d0_done_we", regfile_we_o, 1);
    chk("d0_done_sel", wb_sel_o, 2);

    // Reset mid-MULTI
    cyc(1, 3'b001, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("rstm_en", unit_en_o, 3'b001);
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    chk("rstm_busy_pre", busy_o, 1);
    rst_n = 1'b0;
    cyc(1, 3'b000, 0, 0, 0, 1, 3'b000, 4'd0, 0);
    rst_n = 1'b1;
    cyc(0, 3'b000, 0, 0, 0, 1, 3'b001, 4'd0, 0);
    chk("rstm_busy", busy_o, 0);
    chk("rstm_ready", id_ready_o, 1);
    chk("rstm_we", regfile_we_o, 0);
    chk("no_timeout", timeout_err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
